// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the integer/float register file scoreboard.
//   BANK_INT / BANK_FP : bank select encodings used on rd_bank, iss_bank, wb_bank
//   XLEN_DEF / NREGS_DEF / NRP_DEF : default data width, registers per bank, read ports
// Optional build macro honoured by regfile_scoreboard: REGFILE_WB_BYPASS_EN.
package regfile_pkg;
  localparam logic BANK_INT  = 1'b0;
  localparam logic BANK_FP   = 1'b1;
  localparam int   XLEN_DEF  = 32;
  localparam int   NREGS_DEF = 32;
  localparam int   NRP_DEF   = 2;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: bundle of read, issue and writeback signals of the register file.
//   read    : rd_bank/rd_addr in, rd_data/rd_busy out (per port)
//   issue   : iss_valid/iss_bank/iss_rd in, iss_ready out
//   wb      : wb_valid/wb_bank/wb_rd/wb_data in
//   status  : busy_count, stall out
// master = the pipeline driving requests, slave = the register file.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(2*NREGS) + 1;

  logic [NRP-1:0]           rd_bank;
  logic [NRP-1:0][AW-1:0]   rd_addr;
  logic [NRP-1:0][XLEN-1:0] rd_data;
  logic [NRP-1:0]           rd_busy;
  logic                     iss_valid;
  logic                     iss_bank;
  logic [AW-1:0]            iss_rd;
  logic                     iss_ready;
  logic                     wb_valid;
  logic                     wb_bank;
  logic [AW-1:0]            wb_rd;
  logic [XLEN-1:0]          wb_data;
  logic [CW-1:0]            busy_count;
  logic                     stall;

  modport master (
    output rd_bank, rd_addr, iss_valid, iss_bank, iss_rd,
           wb_valid, wb_bank, wb_rd, wb_data,
    input  rd_data, rd_busy, iss_ready, busy_count, stall
  );
  modport slave (
    input  rd_bank, rd_addr, iss_valid, iss_bank, iss_rd,
           wb_valid, wb_bank, wb_rd, wb_data,
    output rd_data, rd_busy, iss_ready, busy_count, stall
  );
endinterface

// File: rtl/regfile_busy_table.sv
// regfile_busy_table: per-register reservation bits for both banks plus a running count.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   iss_fire       : reservation accepted this cycle (already excludes int x0)
//   iss_bank/iss_rd: reservation target
//   wb_valid/wb_bank/wb_rd : writeback target, clears its busy bit if set
//   busy           : flat busy vector, index = {bank, reg}
//   count          : number of set busy bits
module regfile_busy_table #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(2*NREGS) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iss_fire,
  input  logic               iss_bank,
  input  logic [AW-1:0]      iss_rd,
  input  logic               wb_valid,
  input  logic               wb_bank,
  input  logic [AW-1:0]      wb_rd,
  output logic [2*NREGS-1:0] busy,
  output logic [CW-1:0]      count
);
  logic [2*NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW:0]        iss_idx, wb_idx;

  assign iss_idx = {iss_bank, iss_rd};
  assign wb_idx  = {wb_bank, wb_rd};

  // Clear first, then set: an issue and a wb on the same register leave it
  // reserved. An accepted issue implies the target was idle, so the count
  // simply moves by +1 for the issue and -1 for a wb that actually cleared.
  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (wb_valid && busy_q[wb_idx]) begin
      busy_d[wb_idx] = 1'b0;
      count_d        = count_d - 1'b1;
    end
    if (iss_fire) begin
      busy_d[iss_idx] = 1'b1;
      count_d         = count_d + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy  = busy_q;
  assign count = count_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer + float register banks with a reservation scoreboard.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : NRP combinational read ports (data + busy), one issue
//                  reservation port with ready, one writeback port,
//                  busy_count and stall status.
// Integer x0 is hardwired zero, never reserved, ignores writes.
// Build macro REGFILE_WB_BYPASS_EN: forward a same-cycle writeback to matching
// read ports (data = wb_data, busy = 0); otherwise reads see stored state only.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRP   = NRP_DEF
) (
  input  logic          clock,
  input  logic          reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(2*NREGS) + 1;

  logic [1:0][NREGS-1:0][XLEN-1:0] mem_q, mem_d;
  logic [2*NREGS-1:0]              busy;
  logic                            iss_x0, wb_x0, iss_fire;
  logic [NRP-1:0]                  rd_busy_w;

  assign iss_x0 = (bus.iss_bank == BANK_INT) && (bus.iss_rd == '0);
  assign wb_x0  = (bus.wb_bank  == BANK_INT) && (bus.wb_rd  == '0);

  // Ready looks only at the registered busy bit, so a wb landing this cycle
  // cannot open the way for a WAW reservation on the same target.
  assign bus.iss_ready = iss_x0 || !busy[{bus.iss_bank, bus.iss_rd}];
  assign iss_fire      = bus.iss_valid && bus.iss_ready && !iss_x0;

  regfile_busy_table #(.NREGS(NREGS), .AW(AW), .CW(CW)) u_busy (
    .clock    (clock),
    .reset    (reset),
    .iss_fire (iss_fire),
    .iss_bank (bus.iss_bank),
    .iss_rd   (bus.iss_rd),
    .wb_valid (bus.wb_valid),
    .wb_bank  (bus.wb_bank),
    .wb_rd    (bus.wb_rd),
    .busy     (busy),
    .count    (bus.busy_count)
  );

  always_comb begin
    mem_d = mem_q;
    if (bus.wb_valid && !wb_x0) mem_d[bus.wb_bank][bus.wb_rd] = bus.wb_data;
  end

  always_ff @(posedge clock) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [XLEN-1:0] stored;
    logic            stored_busy;
    assign stored      = mem_q[bus.rd_bank[p]][bus.rd_addr[p]];
    assign stored_busy = busy[{bus.rd_bank[p], bus.rd_addr[p]}];
`ifdef REGFILE_WB_BYPASS_EN
    logic hit;
    assign hit = bus.wb_valid && !wb_x0 &&
                 (bus.wb_bank == bus.rd_bank[p]) && (bus.wb_rd == bus.rd_addr[p]);
    assign bus.rd_data[p] = hit ? bus.wb_data : stored;
    assign rd_busy_w[p]   = stored_busy && !hit;
`else
    assign bus.rd_data[p] = stored;
    assign rd_busy_w[p]   = stored_busy;
`endif
  end

  assign bus.rd_busy = rd_busy_w;
  assign bus.stall   = |rd_busy_w;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector table for the named scenarios, then
// random traffic checked against a register-array reference model.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRP   = 2;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit rst; bit chk;
    bit iv; bit ib; int ir;
    bit wv; bit wb; int wr; logic [31:0] wd;
    bit b0; int a0; bit b1; int a1;
    logic [31:0] d0; logic [31:0] d1;
    bit bz0; bit bz1; bit rdy; int cnt;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;

  logic [31:0] m_data [2][NREGS];
  bit          m_busy [2][NREGS];

  always #5 clock = ~clock;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vec_t mk(bit rst, bit iv, bit ib, int ir,
                              bit wv, bit wb, int wr, logic [31:0] wd,
                              bit b0, int a0, bit b1, int a1,
                              logic [31:0] d0, logic [31:0] d1,
                              bit bz0, bit bz1, bit rdy, int cnt);
    vec_t v;
    v.rst = rst; v.chk = 1'b1;
    v.iv = iv; v.ib = ib; v.ir = ir;
    v.wv = wv; v.wb = wb; v.wr = wr; v.wd = wd;
    v.b0 = b0; v.a0 = a0; v.b1 = b1; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.bz0 = bz0; v.bz1 = bz1; v.rdy = rdy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d actual %h required %h", nm, cur, act, exp);
    end
  endtask

  // Expected outputs straight from the register/busy arrays.
  function automatic vec_t predict(vec_t v);
    vec_t r = v;
    bit   hit;
    int   n = 0;
    hit   = BYP && v.wv && v.wb == v.b0 && v.wr == v.a0 && !(v.b0 == 0 && v.a0 == 0);
    r.d0  = hit ? v.wd : m_data[v.b0][v.a0];
    r.bz0 = hit ? 1'b0 : m_busy[v.b0][v.a0];
    hit   = BYP && v.wv && v.wb == v.b1 && v.wr == v.a1 && !(v.b1 == 0 && v.a1 == 0);
    r.d1  = hit ? v.wd : m_data[v.b1][v.a1];
    r.bz1 = hit ? 1'b0 : m_busy[v.b1][v.a1];
    r.rdy = (v.ib == 0 && v.ir == 0) || !m_busy[v.ib][v.ir];
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NREGS; i++) n += int'(m_busy[b][i]);
    r.cnt = n;
    return r;
  endfunction

  task automatic model_step(vec_t v);
    bit rdy;
    if (v.rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NREGS; i++) begin
          m_data[b][i] = '0;
          m_busy[b][i] = 1'b0;
        end
    end else begin
      rdy = (v.ib == 0 && v.ir == 0) || !m_busy[v.ib][v.ir];
      if (v.wv && !(v.wb == 0 && v.wr == 0)) begin
        m_data[v.wb][v.wr] = v.wd;
        m_busy[v.wb][v.wr] = 1'b0;
      end
      if (v.iv && rdy && !(v.ib == 0 && v.ir == 0)) m_busy[v.ib][v.ir] = 1'b1;
    end
  endtask

  task automatic run(vec_t v, bit use_model);
    vec_t e;
    @(negedge clock);
    reset          = v.rst;
    bus.iss_valid  = v.iv;  bus.iss_bank = v.ib;  bus.iss_rd = v.ir[4:0];
    bus.wb_valid   = v.wv;  bus.wb_bank  = v.wb;  bus.wb_rd  = v.wr[4:0];
    bus.wb_data    = v.wd;
    bus.rd_bank[0] = v.b0;  bus.rd_addr[0] = v.a0[4:0];
    bus.rd_bank[1] = v.b1;  bus.rd_addr[1] = v.a1[4:0];
    e = use_model ? predict(v) : v;
    #1;
    if (v.chk) begin
      chk("rd_data0",   bus.rd_data[0], e.d0);
      chk("rd_data1",   bus.rd_data[1], e.d1);
      chk("rd_busy0",   32'(bus.rd_busy[0]), 32'(e.bz0));
      chk("rd_busy1",   32'(bus.rd_busy[1]), 32'(e.bz1));
      chk("stall",      32'(bus.stall), 32'(e.bz0 | e.bz1));
      chk("iss_ready",  32'(bus.iss_ready), 32'(e.rdy));
      chk("busy_count", 32'(bus.busy_count), e.cnt);
    end
    model_step(v);
    cur++;
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    reset = 1'b1;
    bus.iss_valid = 0; bus.iss_bank = 0; bus.iss_rd = '0;
    bus.wb_valid = 0; bus.wb_bank = 0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.rd_bank = '0; bus.rd_addr = '0;

    //          rst iv ib ir  wv wb wr wd            b0 a0 b1 a1 d0                    d1 bz0      bz1 rdy cnt
    v = mk(1, 0,0,0, 0,0,0,0, 0,5,1,3, 0,0, 0,0,1,0); v.chk = 0; tbl.push_back(v);
    tbl.push_back(mk(0, 0,0,0, 0,0,0,0,            0,5,1,3, 0,                    0, 0,       0, 1, 0));
    tbl.push_back(mk(0, 1,0,7, 0,0,0,0,            0,7,1,3, 0,                    0, 0,       0, 1, 0));
    tbl.push_back(mk(0, 0,0,7, 0,0,0,0,            0,7,1,3, 0,                    0, 1,       0, 0, 1));
    tbl.push_back(mk(0, 0,0,7, 1,0,7,32'hAA,       0,7,1,3, BYP?32'hAA:32'h0,     0, !BYP,    0, 0, 1));
    tbl.push_back(mk(0, 0,0,7, 0,0,0,0,            0,7,1,3, 32'hAA,               0, 0,       0, 1, 0));
    tbl.push_back(mk(0, 1,1,2, 0,0,0,0,            0,7,1,2, 32'hAA,               0, 0,       0, 1, 0));
    tbl.push_back(mk(0, 1,1,2, 0,0,0,0,            0,7,1,2, 32'hAA,               0, 0,       1, 0, 1));
    tbl.push_back(mk(0, 0,1,2, 0,0,0,0,            0,7,1,2, 32'hAA,               0, 0,       1, 0, 1));
    tbl.push_back(mk(0, 1,1,4, 0,0,0,0,            1,4,1,2, 0,                    0, 0,       1, 1, 1));
    tbl.push_back(mk(0, 0,1,4, 1,1,4,32'h3F800000, 1,4,1,2, BYP?32'h3F800000:32'h0, 0, !BYP,  1, 0, 2));
    tbl.push_back(mk(0, 0,1,4, 0,0,0,0,            1,4,1,2, 32'h3F800000,         0, 0,       1, 1, 1));
    tbl.push_back(mk(0, 1,0,0, 1,0,0,32'h1234,     0,0,1,2, 0,                    0, 0,       1, 1, 1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0,0,            0,0,1,2, 0,                    0, 0,       1, 1, 1));
    tbl.push_back(mk(0, 1,0,9, 0,0,0,0,            0,9,1,9, 0,                    0, 0,       0, 1, 1));
    tbl.push_back(mk(0, 1,1,9, 0,0,0,0,            0,9,1,9, 0,                    0, 1,       0, 1, 2));
    tbl.push_back(mk(1, 1,0,3, 1,0,5,32'h55,       0,9,1,9, 0,                    0, 1,       1, 1, 3));
    tbl.push_back(mk(0, 0,0,9, 0,0,0,0,            0,9,1,9, 0,                    0, 0,       0, 1, 0));
    tbl.push_back(mk(0, 0,1,2, 0,0,0,0,            0,7,1,4, 0,                    0, 0,       0, 1, 0));
    tbl.push_back(mk(0, 1,0,3, 1,0,3,32'h77,       0,3,1,4, BYP?32'h77:32'h0,     0, 0,       0, 1, 0));
    tbl.push_back(mk(0, 0,0,3, 0,0,0,0,            0,3,1,4, 32'h77,               0, 1,       0, 0, 1));
    tbl.push_back(mk(0, 0,0,3, 1,0,3,32'h88,       0,3,1,4, BYP?32'h88:32'h77,    0, !BYP,    0, 0, 1));
    tbl.push_back(mk(0, 0,0,3, 0,0,0,0,            0,3,1,4, 32'h88,               0, 0,       0, 1, 0));

    foreach (tbl[i]) run(tbl[i], 1'b0);

    // Random traffic on a small index window so collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      v = mk($urandom_range(0, 40) == 0,
             1'($urandom), 1'($urandom), $urandom_range(0, 7),
             1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom,
             1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
             0, 0, 0, 0, 0, 0);
      run(v, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
